// File: rtl/composite_dac_encoder_if.sv
// Video-side bus of the composite DAC encoder: raw ladder selects in,
// composite sample code and recovered sync timing out.
interface composite_dac_encoder_if #(
  parameter int LINE_W = 12
);
  logic [10:0]       RawVOut;
  logic [7:0]        sample;
  logic              sample_valid;
  logic              sync_active;
  logic              hsync_pulse;
  logic              vsync_pulse;
  logic [LINE_W-1:0] line_len;
  logic              line_len_valid;

  modport master (
    output RawVOut,
    input  sample, sample_valid, sync_active, hsync_pulse, vsync_pulse,
           line_len, line_len_valid
  );

  modport slave (
    input  RawVOut,
    output sample, sample_valid, sync_active, hsync_pulse, vsync_pulse,
           line_len, line_len_valid
  );
endinterface

// File: rtl/composite_dac_encoder.sv
// Converts the video generator's ladder-select bus into composite sample codes
// and recovers horizontal/vertical sync strobes plus measured line length.
module composite_dac_encoder #(
  parameter bit FILTER_EN = 1'b1,
  parameter int HSYNC_MIN = 64,
  parameter int VSYNC_MIN = 400,
  parameter int LINE_W    = 12
) (
  input logic                    CLK,
  input logic                    n_RES,
  composite_dac_encoder_if.slave bus
);

  localparam logic [7:0]        BLANK    = 8'h50;
  localparam logic [9:0]        SYNC_MAX = 10'd1023;
  localparam logic [9:0]        HSYNC_TH = 10'(HSYNC_MIN);
  localparam logic [9:0]        VSYNC_TH = 10'(VSYNC_MIN);
  localparam logic [LINE_W-1:0] LINE_MAX = '1;
  localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

  logic [10:0]       in_q;
  logic [7:0]        lvl;
  logic [7:0]        lvl_t;
  logic [7:0]        lvl_q;
  logic [7:0]        hist1;
  logic [7:0]        hist2;
  logic [7:0]        hist3;
  logic [9:0]        sum;
  logic [1:0]        fill_cnt;
  logic [9:0]        sync_cnt;
  logic              sync_prev;
  logic              sync_fall;
  logic              hs_det;
  logic              vs_det;
  logic [LINE_W-1:0] line_cnt;

  // Highest active tap wins; sync overrides everything and is never tinted.
  always_comb begin
    lvl = BLANK;
    if (in_q[0])      lvl = 8'h00;
    else if (in_q[9]) lvl = 8'hF0;
    else if (in_q[8]) lvl = 8'hC8;
    else if (in_q[7]) lvl = 8'hA8;
    else if (in_q[6]) lvl = 8'h88;
    else if (in_q[5]) lvl = 8'h70;
    else if (in_q[4]) lvl = 8'h58;
    else if (in_q[3]) lvl = 8'h50;
    else if (in_q[2]) lvl = 8'h48;
    else if (in_q[1]) lvl = 8'h38;
    lvl_t = lvl;
    if (in_q[10] && !in_q[0]) lvl_t = lvl - (lvl >> 2);
  end

  assign sum = {2'b00, lvl_q} + {2'b00, hist1} + {2'b00, hist2} + {2'b00, hist3};

  assign sync_fall = sync_prev && !in_q[0];
  assign vs_det    = sync_fall && (sync_cnt >= VSYNC_TH);
  assign hs_det    = sync_fall && !vs_det && (sync_cnt >= HSYNC_TH);

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      in_q             <= '0;
      bus.sync_active  <= 1'b0;
      lvl_q            <= BLANK;
      hist1            <= BLANK;
      hist2            <= BLANK;
      hist3            <= BLANK;
      bus.sample       <= BLANK;
      fill_cnt         <= '0;
      bus.sample_valid <= 1'b0;
    end else begin
      in_q            <= bus.RawVOut;
      bus.sync_active <= bus.RawVOut[0];
      lvl_q           <= lvl_t;
      hist1           <= lvl_q;
      hist2           <= hist1;
      hist3           <= hist2;
      bus.sample      <= FILTER_EN ? sum[9:2] : lvl_q;
      if (fill_cnt != 2'd3) fill_cnt <= fill_cnt + 2'd1;
      if (fill_cnt == 2'd2) bus.sample_valid <= 1'b1;
    end
  end

  // Run length is judged on the cycle after sync drops, then the counter restarts.
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      sync_cnt           <= '0;
      sync_prev          <= 1'b0;
      bus.hsync_pulse    <= 1'b0;
      bus.vsync_pulse    <= 1'b0;
      line_cnt           <= '0;
      bus.line_len       <= '0;
      bus.line_len_valid <= 1'b0;
    end else begin
      sync_prev <= in_q[0];
      if (in_q[0]) begin
        if (sync_cnt != SYNC_MAX) sync_cnt <= sync_cnt + 10'd1;
      end else begin
        sync_cnt <= '0;
      end
      bus.hsync_pulse    <= hs_det;
      bus.vsync_pulse    <= vs_det;
      bus.line_len_valid <= hs_det;
      if (hs_det) bus.line_len <= line_cnt;
      if (hs_det || vs_det)      line_cnt <= LINE_ONE;
      else if (line_cnt != LINE_MAX) line_cnt <= line_cnt + LINE_ONE;
    end
  end

endmodule

// File: tb/tb_composite_dac_encoder.sv
// Bench for composite_dac_encoder: filtered and bypass instances share one
// stimulus stream and are checked against a behavioural model via scoreboards.
module tb_composite_dac_encoder;

  localparam int LINE_W    = 12;
  localparam int HSYNC_MIN = 64;
  localparam int VSYNC_MIN = 400;
  localparam int LINE_MAX  = (1 << LINE_W) - 1;
  localparam logic [7:0] LEVEL_TAB [10] =
    '{8'h50, 8'h38, 8'h48, 8'h50, 8'h58, 8'h70, 8'h88, 8'hA8, 8'hC8, 8'hF0};

  typedef struct packed {
    logic              hs;
    logic              vs;
    logic              llv;
    logic [LINE_W-1:0] len;
  } sync_exp_t;

  typedef struct {
    logic [10:0] raw;
    logic [7:0]  lvl;
  } vec_t;

  logic        CLK;
  logic        n_RES;
  logic [10:0] raw;

  composite_dac_encoder_if #(.LINE_W(LINE_W)) bus_f ();
  composite_dac_encoder_if #(.LINE_W(LINE_W)) bus_b ();

  assign bus_f.RawVOut = raw;
  assign bus_b.RawVOut = raw;

  composite_dac_encoder #(
    .FILTER_EN(1'b1), .HSYNC_MIN(HSYNC_MIN), .VSYNC_MIN(VSYNC_MIN), .LINE_W(LINE_W)
  ) dut_f (
    .CLK(CLK), .n_RES(n_RES), .bus(bus_f)
  );

  composite_dac_encoder #(
    .FILTER_EN(1'b0), .HSYNC_MIN(HSYNC_MIN), .VSYNC_MIN(VSYNC_MIN), .LINE_W(LINE_W)
  ) dut_b (
    .CLK(CLK), .n_RES(n_RES), .bus(bus_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_b_q [$];
  logic [7:0]  exp_f_q [$];
  sync_exp_t   exp_s_q [$];
  vec_t        vecs    [$];

  logic [7:0]        m_h1, m_h2, m_h3;
  int                m_run;
  bit                m_prev;
  int                m_line;
  logic [LINE_W-1:0] m_len;
  int                since_reset;

  int                hs_seen;
  int                vs_seen;
  int                first_len;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [7:0] model_level(input logic [10:0] r);
    int top;
    int l;
    top = 0;
    for (int i = 1; i <= 9; i++) if (r[i]) top = i;
    l = int'(LEVEL_TAB[top]);
    if (r[0]) return 8'h00;
    if (r[10]) l = l - l / 4;
    return 8'(l);
  endfunction

  task automatic reset_model();
    sync_exp_t s;
    m_h1 = 8'h50; m_h2 = 8'h50; m_h3 = 8'h50;
    m_run = 0; m_prev = 1'b0; m_line = 1; m_len = '0;
    since_reset = 0;
    exp_b_q.delete(); exp_f_q.delete(); exp_s_q.delete();
    exp_b_q.push_back(8'h50); exp_b_q.push_back(8'h50);
    exp_f_q.push_back(8'h50); exp_f_q.push_back(8'h50);
    s = '0;
    exp_s_q.push_back(s);
  endtask

  // Asynchronous reset assertion mid-cycle; outputs must fall back at once.
  task automatic do_reset(input bit check_now);
    #2 n_RES = 1'b0;
    #1;
    if (check_now) begin
      check_output("rst_sample_f",  bus_f.sample, 8'h50);
      check_output("rst_sample_b",  bus_b.sample, 8'h50);
      check_output("rst_valid",     bus_f.sample_valid, 1'b0);
      check_output("rst_sync_act",  bus_f.sync_active, 1'b0);
      check_output("rst_hsync",     bus_f.hsync_pulse, 1'b0);
      check_output("rst_vsync",     bus_f.vsync_pulse, 1'b0);
      check_output("rst_line_len",  bus_f.line_len, '0);
      check_output("rst_len_valid", bus_f.line_len_valid, 1'b0);
    end
    repeat (2) @(posedge CLK);
    #3 n_RES = 1'b1;
    reset_model();
  endtask

  task automatic apply_stimulus(input logic [10:0] r);
    logic [7:0] l;
    int         sum;
    sync_exp_t  s;
    raw = r;
    l   = model_level(r);
    exp_b_q.push_back(l);
    sum = int'(l) + int'(m_h1) + int'(m_h2) + int'(m_h3);
    exp_f_q.push_back(8'(sum >> 2));
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = l;
    s = '0;
    if (!r[0] && m_prev) begin
      if (m_run >= VSYNC_MIN) s.vs = 1'b1;
      else if (m_run >= HSYNC_MIN) begin
        s.hs  = 1'b1;
        s.llv = 1'b1;
        m_len = LINE_W'(m_line);
      end
    end
    s.len = m_len;
    if (s.hs || s.vs) m_line = 1;
    else if (m_line < LINE_MAX) m_line++;
    m_run  = r[0] ? ((m_run < 1023) ? m_run + 1 : 1023) : 0;
    m_prev = r[0];
    exp_s_q.push_back(s);

    @(posedge CLK);
    #1;
    since_reset++;
    check_output("sample_bypass", bus_b.sample, exp_b_q.pop_front());
    check_output("sample_filter", bus_f.sample, exp_f_q.pop_front());
    check_output("sync_active",   bus_f.sync_active, r[0]);
    check_output("sample_valid_f", bus_f.sample_valid, since_reset >= 3);
    check_output("sample_valid_b", bus_b.sample_valid, since_reset >= 3);
    s = exp_s_q.pop_front();
    check_output("hsync_pulse",    bus_f.hsync_pulse, s.hs);
    check_output("vsync_pulse",    bus_f.vsync_pulse, s.vs);
    check_output("line_len_valid", bus_f.line_len_valid, s.llv);
    check_output("line_len",       bus_f.line_len, s.len);

    if (bus_f.hsync_pulse === 1'b1) begin
      if (hs_seen == 0) first_len = int'(bus_f.line_len);
      hs_seen++;
    end
    if (bus_f.vsync_pulse === 1'b1) vs_seen++;
  endtask

  initial begin
    int hs_base;
    int vs_base;
    vecs.push_back('{11'h000, 8'h50});
    vecs.push_back('{11'h001, 8'h00});
    vecs.push_back('{11'h002, 8'h38});
    vecs.push_back('{11'h004, 8'h48});
    vecs.push_back('{11'h008, 8'h50});
    vecs.push_back('{11'h010, 8'h58});
    vecs.push_back('{11'h020, 8'h70});
    vecs.push_back('{11'h040, 8'h88});
    vecs.push_back('{11'h080, 8'hA8});
    vecs.push_back('{11'h100, 8'hC8});
    vecs.push_back('{11'h200, 8'hF0});
    vecs.push_back('{11'h480, 8'h7E});
    vecs.push_back('{11'h3FE, 8'hF0});
    vecs.push_back('{11'h600, 8'hB4});
    vecs.push_back('{11'h402, 8'h2A});
    vecs.push_back('{11'h408, 8'h3C});
    vecs.push_back('{11'h601, 8'h00});
    vecs.push_back('{11'h0A0, 8'hA8});

    n_RES = 1'b1; raw = '0; hs_seen = 0; vs_seen = 0; first_len = -1;
    #1 do_reset(1'b1);

    repeat (6) apply_stimulus(11'h000);
    check_output("blank_no_hsync", hs_seen, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      repeat (7) apply_stimulus(vecs[i].raw);
      check_output("table_bypass", bus_b.sample, vecs[i].lvl);
      check_output("table_filter", bus_f.sample, vecs[i].lvl);
    end

    // Filter step response from blank to full white.
    repeat (7) apply_stimulus(11'h000);
    repeat (3) apply_stimulus(11'h200);
    check_output("step_1", bus_f.sample, 8'h78);
    apply_stimulus(11'h200);
    check_output("step_2", bus_f.sample, 8'hA0);
    apply_stimulus(11'h200);
    check_output("step_3", bus_f.sample, 8'hC8);
    apply_stimulus(11'h200);
    check_output("step_4", bus_f.sample, 8'hF0);

    // Three regular lines of 100 sync + 1264 active.
    do_reset(1'b0);
    hs_seen = 0; vs_seen = 0; first_len = -1;
    for (int ln = 0; ln < 3; ln++) begin
      repeat (100)  apply_stimulus(11'h001);
      repeat (1264) apply_stimulus(11'h000);
    end
    check_output("line_hs_count", hs_seen, 3);
    check_output("line_vs_count", vs_seen, 0);
    check_output("line_first_len", first_len, 101);
    check_output("line_len_1364", bus_f.line_len, 1364);

    // Short glitch is ignored and does not restart the line counter.
    repeat (40)  apply_stimulus(11'h001);
    repeat (200) apply_stimulus(11'h000);
    repeat (100) apply_stimulus(11'h001);
    repeat (50)  apply_stimulus(11'h000);
    check_output("glitch_hs_count", hs_seen, 4);
    check_output("glitch_line_len", bus_f.line_len, 1604);

    // Broad sync: vsync strobe, line_len held, counter restarted.
    repeat (500) apply_stimulus(11'h001);
    repeat (300) apply_stimulus(11'h000);
    check_output("vsync_count", vs_seen, 1);
    check_output("vsync_hs_count", hs_seen, 4);
    check_output("vsync_len_held", bus_f.line_len, 1604);
    repeat (100) apply_stimulus(11'h001);
    repeat (50)  apply_stimulus(11'h000);
    check_output("post_vsync_len", bus_f.line_len, 400);

    // Reset in the middle of a sync run, then a qualifying remainder.
    repeat (50) apply_stimulus(11'h001);
    do_reset(1'b1);
    hs_base = hs_seen; vs_base = vs_seen;
    repeat (70) apply_stimulus(11'h001);
    repeat (50) apply_stimulus(11'h000);
    check_output("rem70_hsync", hs_seen, hs_base + 1);
    check_output("rem70_len", bus_f.line_len, 71);

    // Reset in the middle of a sync run, then a too-short remainder.
    repeat (20) apply_stimulus(11'h001);
    do_reset(1'b1);
    hs_base = hs_seen;
    repeat (30) apply_stimulus(11'h001);
    repeat (50) apply_stimulus(11'h000);
    check_output("rem30_no_hsync", hs_seen, hs_base);
    check_output("rem30_no_vsync", vs_seen, vs_base);
    check_output("rem30_len_zero", bus_f.line_len, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/composite_dac_encoder.md
Name: composite_dac_encoder

Overview:
- Downstream of the video generator.
- Consumes its 11-bit ladder-select bus RawVOut at master-clock rate and converts it to a digital composite sample code for an external DAC or capture path.
- Applies the emphasis attenuation signalled on RawVOut[10], optionally box-filters the samples, and recovers horizontal/vertical sync timing plus measured line length for downstream capture logic.

Parameters:
- FILTER_EN, 1, 1 = 4-tap box filter on output; 0 = bypass (latency unchanged)
- HSYNC_MIN, 64, minimum sync-low run (CLK cycles) classified as horizontal sync
- VSYNC_MIN, 400, minimum sync run classified as vertical/broad sync
- LINE_W, 12, width of line-length counter and output

Ports:
- CLK  in  1  master clock, all logic on rising edge
- n_RES  in  1  asynchronous, active-low reset
- RawVOut  in  11  ladder selects from video generator; [0] sync, [9:1] level taps, [10] TINT
- sample  out  8  composite sample code
- sample_valid  out  1  sample pipeline filled
- sync_active  out  1  registered RawVOut[0]
- hsync_pulse  out  1  one-cycle strobe, end of horizontal sync
- vsync_pulse  out  1  one-cycle strobe, end of vertical sync
- line_len  out  LINE_W  CLK cycles between last two hsync strobes
- line_len_valid  out  1  one-cycle strobe when line_len updates

Behaviour:
- Reset values (n_RES low, immediate):
  - sample = 0x50; sample_valid, sync_active, hsync_pulse, vsync_pulse, line_len_valid = 0; line_len = 0.
  - All pipeline and filter history registers = 0x50; sync counter = 0; line counter = 0.
- S0 (edge 1): register RawVOut into in_q. sync_active = in_q[0].
- S1 (edge 2): level lookup from in_q, by priority:
  - in_q[0] = 1 → 0x00.
  - Otherwise the highest set bit of in_q[9:1] selects: 1→0x38, 2→0x48, 3→0x50, 4→0x58, 5→0x70, 6→0x88, 7→0xA8, 8→0xC8, 9→0xF0.
  - No bit set → 0x50 (blank).
  - Tint: if in_q[10] = 1 and in_q[0] = 0, lvl_t = lvl − (lvl >> 2), truncating, 8-bit, no underflow possible. Otherwise lvl_t = lvl.
- S2 (edge 3):
  - FILTER_EN = 1: sum of the current lvl_t and the 3 previous lvl_t values (10-bit, no overflow); sample = sum[9:2].
  - FILTER_EN = 0: sample = lvl_t.
- Latency: RawVOut change at edge N appears on sample after edge N+3. With the filter, it is fully settled after edge N+6.
- sample_valid: goes 1 on the 3rd rising edge after n_RES deasserts and stays 1 until reset.
- Sync detector (operates on in_q[0]):
  - sync_cnt increments each cycle in_q[0] = 1, saturating at 1023.
  - Cleared on the cycle after a 1→0 transition.
  - On a 1→0 transition, the next edge gives:
    - sync_cnt ≥ VSYNC_MIN → vsync_pulse = 1.
    - Else sync_cnt ≥ HSYNC_MIN → hsync_pulse = 1.
    - Else no strobe (glitch rejected).
  - Strobes last exactly one cycle and are mutually exclusive.
- Line counter:
  - Increments every cycle, saturating at 2^LINE_W − 1.
  - On hsync_pulse: line_len = counter value, line_len_valid = 1 for that cycle, counter = 1.
  - On vsync_pulse: counter = 1 and line_len is unchanged; no valid strobe.
  - The first hsync after reset or after a vsync still updates line_len, with the partial count.
- Sync still asserted at reset release: the counter starts from 0, and a strobe is produced only if the run length qualifies.
- Reset mid-line: all state is lost immediately, and line_len returns to 0 until the next hsync.

Test Plan:
- Reset, then RawVOut = 0 held → sample = 0x50; sample_valid rises at the 3rd edge; no strobes.
- FILTER_EN = 0, RawVOut = 0x080 (bit7) → sample = 0xA8 after 3 edges. RawVOut = 0x480 (bit7 + TINT) → 0x7E.
- FILTER_EN = 1, step from 0x50-level to bit9 (0xF0) → samples 0x78, 0xA0, 0xC8, 0xF0 on successive cycles.
- Sync run of 100 cycles, then 1264 cycles low, repeated → hsync_pulse once per line; second line_len = 1364 with line_len_valid strobe; vsync_pulse = 0.
- Sync runs of 40 and of 500 cycles → 40: no strobe, line counter unaffected. 500: vsync_pulse one cycle, line_len unchanged, counter restarts at 1.
- n_RES asserted mid-sync with RawVOut[0] = 1 → all outputs return to reset values immediately. After release, a 70-cycle remainder gives hsync_pulse; a 30-cycle remainder gives none.
